// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
// Module : sys_pkg
// Brief  : Shared constants, FSM state encoding and request entry layout.
// Rev    : 1.0  initial release
// ============================================================================
package sys_pkg;

  localparam int unsigned INSTR_SYSCALL = 32'd26;
  localparam int unsigned SYS_DISPLAY   = 32'd1;
  localparam int unsigned SYS_EXIT      = 32'd2;
  localparam int unsigned SYS_WIDTH     = 32'd32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXIT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } sys_state_e;

  typedef struct packed {
    logic [SYS_WIDTH-1:0] code;
    logic [SYS_WIDTH-1:0] data;
  } sys_req_t;

endpackage
`default_nettype wire

// File: rtl/sys_req_fifo.sv
`default_nettype none
// ============================================================================
// Module : sys_req_fifo
// Brief  : In-order request queue; pointers carry one extra wrap bit.
// Rev    : 1.0  initial release
// ============================================================================
module sys_req_fifo #(
  parameter int DEPTH = 4,
  parameter int EW    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [EW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [EW-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_ONE = {{AW{1'b0}}, 1'b1};

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          w_push;
  logic          w_pop;

  // Full wins over a same-cycle pop: no write-through.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_head  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + C_ONE;
      if (w_pop)  r_rp <= r_rp + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/syscall_issue.sv
`default_nettype none
// ============================================================================
// Module : syscall_issue
// Brief  : Syscall decode, request queueing and exit/halt sequencing.
//          Optional SYSCALL_COUNT_EN adds disp_count (transferred displays).
// Rev    : 1.0  initial release
// ============================================================================
module syscall_issue
  import sys_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [31:0]      instr_ID,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             stall,
  output logic             sys_req_valid,
  output logic [WIDTH-1:0] sys_req_code,
  output logic [WIDTH-1:0] sys_req_data,
  input  logic             sys_req_ready,
  output logic             halted
`ifdef SYSCALL_COUNT_EN
  ,
  output logic [31:0]      disp_count
`endif
);

  sys_state_e         r_state;
  sys_state_e         w_next;
  logic               w_is_sys;
  logic               w_is_disp;
  logic               w_is_exit;
  logic               w_pushable;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [2*WIDTH-1:0] w_entry;
  logic [2*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   w_head_code;

  assign w_is_sys   = issue_valid && (instr_ID == INSTR_SYSCALL);
  assign w_is_disp  = (rs == WIDTH'(SYS_DISPLAY));
  assign w_is_exit  = (rs == WIDTH'(SYS_EXIT));
  assign w_pushable = w_is_sys && (w_is_disp || w_is_exit);

  assign stall  = (r_state != ST_IDLE) || (w_pushable && w_full);
  assign w_push = w_pushable && !stall;

  assign w_entry = w_is_exit ? {WIDTH'(SYS_EXIT), {WIDTH{1'b0}}}
                             : {WIDTH'(SYS_DISPLAY), rt};

  sys_req_fifo #(
    .DEPTH (DEPTH),
    .EW    (2*WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign w_head_code   = w_head[2*WIDTH-1:WIDTH];
  assign sys_req_valid = !w_empty && (r_state != ST_HALTED);
  assign w_pop         = sys_req_valid && sys_req_ready;
  // Head is masked to zero when idle so outputs match reset values.
  assign sys_req_code  = sys_req_valid ? w_head_code : '0;
  assign sys_req_data  = sys_req_valid ? w_head[WIDTH-1:0] : '0;
  assign halted        = (r_state == ST_HALTED);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_push && w_is_exit) w_next = ST_EXIT_PEND;
      ST_EXIT_PEND: if (w_pop && (w_head_code == WIDTH'(SYS_EXIT))) w_next = ST_HALTED;
      ST_HALTED:    w_next = ST_HALTED;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

`ifdef SYSCALL_COUNT_EN
  logic [31:0] r_disp_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp_count <= '0;
    end else if (w_pop && (w_head_code == WIDTH'(SYS_DISPLAY)) && (r_state != ST_HALTED)) begin
      r_disp_count <= r_disp_count + 32'd1;
    end
  end

  assign disp_count = r_disp_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_syscall_issue.sv
`default_nettype none
// ============================================================================
// Module : tb_syscall_issue
// Brief  : Directed self-checking bench for syscall_issue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_syscall_issue;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [31:0] instr_ID;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        stall;
  logic        sys_req_valid;
  logic [31:0] sys_req_code;
  logic [31:0] sys_req_data;
  logic        sys_req_ready;
  logic        halted;
`ifdef SYSCALL_COUNT_EN
  logic [31:0] disp_count;
`endif

  int n_checks;
  int n_errors;

  syscall_issue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .instr_ID      (instr_ID),
    .rs            (rs),
    .rt            (rt),
    .stall         (stall),
    .sys_req_valid (sys_req_valid),
    .sys_req_code  (sys_req_code),
    .sys_req_data  (sys_req_data),
    .sys_req_ready (sys_req_ready),
    .halted        (halted)
`ifdef SYSCALL_COUNT_EN
    ,
    .disp_count    (disp_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] id, input logic [31:0] r_s,
                       input logic [31:0] r_t);
    issue_valid = v;
    instr_ID    = id;
    rs          = r_s;
    rt          = r_t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    sys_req_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);

    // Reset values
    step(); step();
    chk("rst_valid", 32'(sys_req_valid), 32'd0);
    chk("rst_code", sys_req_code, 32'd0);
    chk("rst_data", sys_req_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    reset = 1'b1;

    // Single display, responder ready
    drive(1'b1, 32'd26, 32'd1, 32'h1234);
    sys_req_ready = 1'b1;
    #1 chk("t1_stall", 32'(stall), 32'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("t1_valid", 32'(sys_req_valid), 32'd1);
    chk("t1_code", sys_req_code, 32'd1);
    chk("t1_data", sys_req_data, 32'h1234);
    chk("t1_stall2", 32'(stall), 32'd0);
    step();
    chk("t1_popped", 32'(sys_req_valid), 32'd0);

    // Fill to full, fifth display stalls
    sys_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd26, 32'd1, 32'hA0 + 32'(i));
      #1 chk("t2_fill_stall", 32'(stall), 32'd0);
      step();
    end
    drive(1'b1, 32'd26, 32'd1, 32'hA4);
    #1;
    chk("t2_full_stall", 32'(stall), 32'd1);
    chk("t2_head0", sys_req_data, 32'hA0);
    step();
    sys_req_ready = 1'b1;
    #1;
    chk("t2_full_pop_stall", 32'(stall), 32'd1);
    chk("t2_head0_hold", sys_req_data, 32'hA0);
    step();
    chk("t2_unstall", 32'(stall), 32'd0);
    chk("t2_head1", sys_req_data, 32'hA1);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #1 chk("t2_head2", sys_req_data, 32'hA2);
    step();
    chk("t2_head3", sys_req_data, 32'hA3);
    step();
    chk("t2_head4", sys_req_data, 32'hA4);
    step();
    chk("t2_drained", 32'(sys_req_valid), 32'd0);

    // Nop syscall and non-syscall instruction
    sys_req_ready = 1'b0;
    drive(1'b1, 32'd26, 32'd7, 32'h55);
    #1 chk("t3_nop_stall", 32'(stall), 32'd0);
    step();
    drive(1'b1, 32'd5, 32'd1, 32'h66);
    #1;
    chk("t3_other_stall", 32'(stall), 32'd0);
    chk("t3_nop_valid", 32'(sys_req_valid), 32'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #1 chk("t3_other_valid", 32'(sys_req_valid), 32'd0);

    // Asynchronous reset with entries queued in EXIT_PEND
    drive(1'b1, 32'd26, 32'd1, 32'hD0); step();
    drive(1'b1, 32'd26, 32'd1, 32'hD1); step();
    drive(1'b1, 32'd26, 32'd2, 32'hFF); step();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("t5_pend_stall", 32'(stall), 32'd1);
    chk("t5_pend_valid", 32'(sys_req_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_valid", 32'(sys_req_valid), 32'd0);
    chk("t5_async_stall", 32'(stall), 32'd0);
    chk("t5_async_code", sys_req_code, 32'd0);
    chk("t5_async_data", sys_req_data, 32'd0);
    chk("t5_async_halted", 32'(halted), 32'd0);
    step();
    reset = 1'b1;
    drive(1'b1, 32'd26, 32'd1, 32'hC0);
    sys_req_ready = 1'b1;
    #1 chk("t5_post_stall", 32'(stall), 32'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("t5_post_valid", 32'(sys_req_valid), 32'd1);
    chk("t5_post_data", sys_req_data, 32'hC0);
    step();
    chk("t5_post_empty", 32'(sys_req_valid), 32'd0);

    // Displays then exit, drain and halt
    sys_req_ready = 1'b0;
    drive(1'b1, 32'd26, 32'd1, 32'hB0); step();
    drive(1'b1, 32'd26, 32'd1, 32'hB1); step();
    drive(1'b1, 32'd26, 32'd2, 32'h77);
    #1 chk("t4_exit_accept_stall", 32'(stall), 32'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    sys_req_ready = 1'b1;
    #1;
    chk("t4_pend_stall", 32'(stall), 32'd1);
    chk("t4_b0_code", sys_req_code, 32'd1);
    chk("t4_b0_data", sys_req_data, 32'hB0);
    step();
    chk("t4_b1_data", sys_req_data, 32'hB1);
    step();
    chk("t4_exit_code", sys_req_code, 32'd2);
    chk("t4_exit_data", sys_req_data, 32'd0);
    chk("t4_not_halted", 32'(halted), 32'd0);
    step();
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_halt_stall", 32'(stall), 32'd1);
    chk("t4_halt_valid", 32'(sys_req_valid), 32'd0);
    drive(1'b1, 32'd26, 32'd1, 32'hEE);
    #1 chk("t4_halt_issue_stall", 32'(stall), 32'd1);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("t4_halt_no_push", 32'(sys_req_valid), 32'd0);
    chk("t4_halt_sticky", 32'(halted), 32'd1);
`ifdef SYSCALL_COUNT_EN
    chk("cnt_at_halt", disp_count, 32'd3);
    step(); step();
    chk("cnt_frozen", disp_count, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
